// File: rtl/xbus_arb.sv
// Arbitrates the CPU and disk DMA onto the xbus; round-robin on contention, wait timeout flags NXM.
// Registered outputs: x_req one edge after request sampled in IDLE; requesters held off by level req until ack.
module xbus_arb #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [21:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_nxm,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [21:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic        dma_nxm,
  output logic [31:0] rdata,
  output logic [1:0]  grant,
  output logic        x_req,
  output logic        x_wr,
  output logic [21:0] x_addr,
  output logic [31:0] x_wdata,
  input  logic        x_ack,
  input  logic [31:0] x_rdata
);

  typedef enum logic [1:0] {IDLE, CPU_CYC, DMA_CYC, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        last_dma, last_dma_nxt;
  logic        x_req_nxt, x_wr_nxt;
  logic [21:0] x_addr_nxt;
  logic [31:0] x_wdata_nxt, rdata_nxt;
  logic [1:0]  grant_nxt;
  logic        cpu_ack_nxt, cpu_nxm_nxt, dma_ack_nxt, dma_nxm_nxt;
  logic        owner_dma;
  logic        timed_out;

  assign owner_dma = (state == DMA_CYC);
  // Fires on the edge that would leave x_req high for more than TIMEOUT cycles.
  assign timed_out = ((wait_cnt + 8'd1) == TIMEOUT);

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      last_dma <= 1'b1;
      x_req    <= 1'b0;
      x_wr     <= 1'b0;
      x_addr   <= 22'd0;
      x_wdata  <= 32'd0;
      rdata    <= 32'd0;
      grant    <= 2'b00;
      cpu_ack  <= 1'b0;
      cpu_nxm  <= 1'b0;
      dma_ack  <= 1'b0;
      dma_nxm  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      last_dma <= last_dma_nxt;
      x_req    <= x_req_nxt;
      x_wr     <= x_wr_nxt;
      x_addr   <= x_addr_nxt;
      x_wdata  <= x_wdata_nxt;
      rdata    <= rdata_nxt;
      grant    <= grant_nxt;
      cpu_ack  <= cpu_ack_nxt;
      cpu_nxm  <= cpu_nxm_nxt;
      dma_ack  <= dma_ack_nxt;
      dma_nxm  <= dma_nxm_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    last_dma_nxt = last_dma;
    x_req_nxt    = x_req;
    x_wr_nxt     = x_wr;
    x_addr_nxt   = x_addr;
    x_wdata_nxt  = x_wdata;
    rdata_nxt    = rdata;
    grant_nxt    = grant;
    cpu_ack_nxt  = 1'b0;
    cpu_nxm_nxt  = 1'b0;
    dma_ack_nxt  = 1'b0;
    dma_nxm_nxt  = 1'b0;

    case (state)
      IDLE: begin
        // On contention the side that was not served last wins.
        if (cpu_req && (!dma_req || last_dma)) begin
          state_nxt    = CPU_CYC;
          wait_cnt_nxt = 8'd0;
          last_dma_nxt = 1'b0;
          x_req_nxt    = 1'b1;
          x_wr_nxt     = cpu_wr;
          x_addr_nxt   = cpu_addr;
          x_wdata_nxt  = cpu_wdata;
          grant_nxt    = 2'b01;
        end else if (dma_req) begin
          state_nxt    = DMA_CYC;
          wait_cnt_nxt = 8'd0;
          last_dma_nxt = 1'b1;
          x_req_nxt    = 1'b1;
          x_wr_nxt     = dma_wr;
          x_addr_nxt   = dma_addr;
          x_wdata_nxt  = dma_wdata;
          grant_nxt    = 2'b10;
        end
      end

      CPU_CYC, DMA_CYC: begin
        if (x_ack) begin
          state_nxt   = DONE;
          x_req_nxt   = 1'b0;
          grant_nxt   = 2'b00;
          cpu_ack_nxt = !owner_dma;
          dma_ack_nxt = owner_dma;
          if (!x_wr) begin
            rdata_nxt = x_rdata;
          end
        end else if (timed_out) begin
          state_nxt   = DONE;
          x_req_nxt   = 1'b0;
          grant_nxt   = 2'b00;
          cpu_ack_nxt = !owner_dma;
          cpu_nxm_nxt = !owner_dma;
          dma_ack_nxt = owner_dma;
          dma_nxm_nxt = owner_dma;
          rdata_nxt   = 32'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/xbus_arb.md
XBUS_ARB -- requirements
Module: xbus_arb

Interface
REQ-001 Parameter TIMEOUT, default 8'd64, number of cycles x_req may stay high without x_ack before the cycle is aborted; legal range 1..255.
REQ-002 mclk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU requests an xbus cycle; level, held until cpu_ack.
REQ-005 cpu_wr  input  1  1 = write, 0 = read; valid with cpu_req.
REQ-006 cpu_addr  input  22  CPU xbus word address.
REQ-007 cpu_wdata  input  32  CPU write data.
REQ-008 cpu_ack  output  1  one-cycle completion pulse to the CPU.
REQ-009 cpu_nxm  output  1  one-cycle pulse coincident with cpu_ack when the cycle timed out.
REQ-010 dma_req, dma_wr, dma_addr[21:0], dma_wdata[31:0]  inputs  disk DMA requester, same meaning as the cpu_* inputs.
REQ-011 dma_ack, dma_nxm  outputs  1 each  DMA completion and timeout pulses, same rules as the cpu_* outputs.
REQ-012 rdata  output  32  read data returned to whichever requester is acked; held until the next completion.
REQ-013 grant  output  2  one-hot current owner: 01 = CPU, 10 = DMA, 00 = none.
REQ-014 x_req  output  1  xbus request to the slave side.
REQ-015 x_wr, x_addr[21:0], x_wdata[31:0]  outputs  xbus cycle type, address and write data.
REQ-016 x_ack  input  1  active-high slave acknowledge.
REQ-017 x_rdata  input  32  slave read data, valid with x_ack.

Function
REQ-018 States SHALL be IDLE, CPU_CYC, DMA_CYC and DONE; all outputs SHALL be registered.
REQ-019 IDLE, exactly one requester high: the next edge SHALL enter that requester's CYC state.
REQ-020 IDLE, both requesters high: the requester not granted last SHALL win. last_grant resets to DMA, so the CPU wins first.
REQ-021 On entering a CYC state, the block SHALL latch wr/addr/wdata from the winner, drive x_req=1 and set grant.
- x_req rises one edge after the req is sampled high in IDLE.
REQ-022 x_wr, x_addr and x_wdata SHALL stay stable for the whole time x_req=1.
- Changes on the requester inputs during the cycle are ignored.
REQ-023 A requester dropping its req mid-cycle SHALL NOT abort the cycle; the cycle completes and its ack is still pulsed.
REQ-024 x_ack sampled 1 in a CYC state at edge k: at edge k the block SHALL
- drive x_req=0 and grant=00;
- pulse the owner's ack for one cycle;
- load rdata from x_rdata on reads (rdata unchanged on writes);
- enter DONE.
REQ-025 An 8-bit wait counter SHALL clear on grant and increment on each edge in a CYC state without x_ack.
REQ-026 When the counter reaches TIMEOUT (x_req high for TIMEOUT cycles), the block SHALL
- drop x_req;
- pulse the owner's ack and nxm together;
- set rdata=0;
- enter DONE.
REQ-027 If x_ack and timeout coincide, x_ack SHALL win and nxm SHALL stay 0.
REQ-028 DONE SHALL last exactly one cycle with x_req=0, then go to IDLE.
- A req still high in IDLE is a new request.
- Minimum spacing between x_req pulses is 2 cycles.
REQ-029 x_ack while in IDLE or DONE SHALL be ignored.
REQ-030 ack and nxm SHALL never be high for both requesters in the same cycle.

Reset
REQ-031 While reset=1, outputs SHALL go immediately to:
- x_req, cpu_ack, dma_ack, cpu_nxm, dma_nxm = 0;
- grant = 00, rdata = 0, x_addr/x_wdata/x_wr = 0.
REQ-032 Reset SHALL also force state=IDLE, counter=0 and last_grant=DMA, including mid-cycle; an interrupted cycle is not acked.

Verification
REQ-033 CPU read of addr 22'o00000000, x_ack 3 cycles after x_req with x_rdata=32'o0101 -> cpu_ack one cycle, rdata=32'o0101, cpu_nxm=0, grant 01 then 00.
REQ-034 cpu_req and dma_req rise together after reset and are re-raised after each ack -> order CPU, DMA, CPU, DMA; one DONE gap between x_req pulses.
REQ-035 DMA write addr 22'o17377775 data 32'h00001234 with cpu_addr toggling during the cycle -> x_wr=1, x_addr and x_wdata constant until dma_ack.
REQ-036 TIMEOUT=8, CPU read, no x_ack -> x_req high exactly 8 cycles, then cpu_ack=cpu_nxm=1 for one cycle, rdata=0.
REQ-037 reset pulsed 2 cycles into a DMA cycle with dma_req held -> outputs zero asynchronously, no dma_ack; after release x_req reissued with the same address.
REQ-038 x_ack pulsed in IDLE -> no ack, nxm or state change.
